// File: rtl/adma_transfer_engine_pkg.sv
// rtl/adma_transfer_engine_pkg.sv - shared state encodings and direction codes for the ADMA transfer engine
package adma_transfer_engine_pkg;

    localparam int ADDR_W = 64;
    localparam int LEN_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_XF   = 3'd3,
        ST_DONE = 3'd4
    } adma_state_e;

    localparam logic DIR_RAM_TO_FIFO = 1'b1;
    localparam logic DIR_FIFO_TO_RAM = 1'b0;

endpackage

// File: rtl/adma_xfer_counter.sv
// rtl/adma_xfer_counter.sv - RAM address and remaining-word counter for one ADMA transfer
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   load_i                 load address_init_i / length_i (transfer accepted)
//   step_i                 one word moved: advance address, decrement count
//   address_init_i         first RAM byte address
//   length_i               words to transfer
//   ram_address_o          current RAM byte address (registered)
//   words_remaining_o      words still to move (registered)
//   last_o                 exactly one word left
module adma_xfer_counter
    import adma_transfer_engine_pkg::*;
#(
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] address_init_i,
    input  logic [LEN_W-1:0]  length_i,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic [LEN_W-1:0]  words_remaining_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = address_init_i;
            rem_d  = length_i;
        end else if (step_i) begin
            // Address wraps modulo 2^64 without complaint.
            addr_d = addr_q + ADDR_W'(ADDR_STEP);
            rem_d  = rem_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign ram_address_o     = addr_q;
    assign words_remaining_o = rem_q;
    assign last_o            = (rem_q == LEN_W'(1));

endmodule

// File: rtl/adma_transfer_engine.sv
// rtl/adma_transfer_engine.sv - moves a block of words between system RAM and the data FIFO on request
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   start_i, direction_i,
//   length_i, address_init_i       transfer request, sampled only when idle
//   ram_address_o                  current RAM byte address
//   ram_read_en_o, ram_write_en_o  RAM strobes (read data valid the following cycle)
//   ram_data_in_i, ram_data_out_o  RAM data buses
//   fifo_push_o, fifo_data_out_o,
//   fifo_full_i                    FIFO write side
//   fifo_pop_o, fifo_data_in_i,
//   fifo_empty_i                   FIFO read side (first-word-fall-through)
//   busy_o                         any state but idle
//   transfer_complete_o            one-cycle completion pulse
//   words_remaining_o              words not yet moved
module adma_transfer_engine
    import adma_transfer_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_STEP  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  direction_i,
    input  logic [LEN_W-1:0]      length_i,
    input  logic [ADDR_W-1:0]     address_init_i,
    output logic [ADDR_W-1:0]     ram_address_o,
    output logic                  ram_read_en_o,
    output logic                  ram_write_en_o,
    input  logic [DATA_WIDTH-1:0] ram_data_in_i,
    output logic [DATA_WIDTH-1:0] ram_data_out_o,
    output logic                  fifo_push_o,
    output logic [DATA_WIDTH-1:0] fifo_data_out_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_pop_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_in_i,
    input  logic                  fifo_empty_i,
    output logic                  busy_o,
    output logic                  transfer_complete_o,
    output logic [LEN_W-1:0]      words_remaining_o
);

    adma_state_e state_q, state_d;
    logic        dir_q, dir_d;
    logic        load, step, last;

    adma_xfer_counter #(
        .ADDR_STEP(ADDR_STEP)
    ) u_counter (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .load_i           (load),
        .step_i           (step),
        .address_init_i   (address_init_i),
        .length_i         (length_i),
        .ram_address_o    (ram_address_o),
        .words_remaining_o(words_remaining_o),
        .last_o           (last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_RAM_TO_FIFO;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        dir_d               = dir_q;
        load                = 1'b0;
        step                = 1'b0;
        ram_read_en_o       = 1'b0;
        ram_write_en_o      = 1'b0;
        fifo_push_o         = 1'b0;
        fifo_pop_o          = 1'b0;
        transfer_complete_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load  = 1'b1;
                    dir_d = direction_i;
                    if (length_i == '0)
                        state_d = ST_DONE;
                    else if (direction_i == DIR_RAM_TO_FIFO)
                        state_d = ST_RD;
                    else
                        state_d = ST_XF;
                end
            end
            // The latched direction also qualifies each data path so a
            // state upset can never strobe the path opposite to the request.
            ST_RD: begin
                if (dir_q == DIR_RAM_TO_FIFO && !fifo_full_i) begin
                    ram_read_en_o = 1'b1;
                    state_d       = ST_WR;
                end
            end
            // The engine is the only FIFO writer, so the space seen in RD
            // is still there when the read data arrives.
            ST_WR: begin
                fifo_push_o = 1'b1;
                step        = 1'b1;
                state_d     = last ? ST_DONE : ST_RD;
            end
            ST_XF: begin
                if (dir_q == DIR_FIFO_TO_RAM && !fifo_empty_i) begin
                    fifo_pop_o     = 1'b1;
                    ram_write_en_o = 1'b1;
                    step           = 1'b1;
                    if (last)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                transfer_complete_o = 1'b1;
                state_d             = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o          = (state_q != ST_IDLE);
    assign ram_data_out_o  = fifo_data_in_i;
    assign fifo_data_out_o = ram_data_in_i;

endmodule

// File: tb/tb_adma_transfer_engine.sv
// tb/tb_adma_transfer_engine.sv - scoreboard bench for adma_transfer_engine
module tb_adma_transfer_engine;

    localparam int EV_RD   = 0;
    localparam int EV_PUSH = 1;
    localparam int EV_WR   = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int          kind;
        logic [63:0] addr;
        logic [31:0] data;
        logic [15:0] rem;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        direction = 1'b0;
    logic [15:0] length = '0;
    logic [63:0] address_init = '0;
    logic [63:0] ram_address;
    logic        ram_read_en, ram_write_en;
    logic [31:0] ram_data_in = '0;
    logic [31:0] ram_data_out;
    logic        fifo_push, fifo_pop;
    logic [31:0] fifo_data_out;
    logic        fifo_full = 1'b0;
    logic [31:0] fifo_head = '0;
    int          fifo_cnt = 0;
    logic        fifo_empty;
    logic        busy, transfer_complete;
    logic [15:0] words_remaining;

    ev_t         exp_q[$];
    logic [31:0] fq[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    assign fifo_empty = (fifo_cnt == 0);

    always #5 clk = ~clk;

    adma_transfer_engine #(.DATA_WIDTH(32), .ADDR_STEP(4)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .start_i            (start),
        .direction_i        (direction),
        .length_i           (length),
        .address_init_i     (address_init),
        .ram_address_o      (ram_address),
        .ram_read_en_o      (ram_read_en),
        .ram_write_en_o     (ram_write_en),
        .ram_data_in_i      (ram_data_in),
        .ram_data_out_o     (ram_data_out),
        .fifo_push_o        (fifo_push),
        .fifo_data_out_o    (fifo_data_out),
        .fifo_full_i        (fifo_full),
        .fifo_pop_o         (fifo_pop),
        .fifo_data_in_i     (fifo_head),
        .fifo_empty_i       (fifo_empty),
        .busy_o             (busy),
        .transfer_complete_o(transfer_complete),
        .words_remaining_o  (words_remaining)
    );

    // RAM model: read data is the low word of the address, one cycle later.
    always @(posedge clk) begin
        if (ram_read_en)
            ram_data_in <= ram_address[31:0];
    end

    // FIFO model: first-word-fall-through view of the fq queue.
    always @(posedge clk) begin
        if (fifo_pop && fq.size() > 0)
            void'(fq.pop_front());
        fifo_cnt  <= fq.size();
        fifo_head <= (fq.size() > 0) ? fq[0] : 32'h0;
    end

    function automatic void expect_ev(int kind, logic [63:0] a, logic [31:0] d, logic [15:0] r);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d; e.rem = r;
        exp_q.push_back(e);
    endfunction

    function automatic void check_ev(int kind, logic [63:0] a, logic [31:0] d, logic [15:0] r);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h rem=%0d, required no event",
                     kind, a, d, r);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.addr != a || e.rem != r ||
            ((kind == EV_PUSH || kind == EV_WR) && e.data != d)) begin
            n_fail++;
            $display("FAIL event: got kind=%0d addr=%0h data=%0h rem=%0d, required kind=%0d addr=%0h data=%0h rem=%0d",
                     kind, a, d, r, e.kind, e.addr, e.data, e.rem);
        end
    endfunction

    // Monitor: every observable strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if ((ram_read_en && ram_write_en) || (fifo_push && fifo_pop) ||
                (ram_write_en != fifo_pop) || (ram_write_en && fifo_empty)) begin
                n_fail++;
                $display("FAIL strobe_rules: got rd=%0b wr=%0b push=%0b pop=%0b empty=%0b, required exclusive strobes, pop==wr, no wr when empty",
                         ram_read_en, ram_write_en, fifo_push, fifo_pop, fifo_empty);
            end
            if (ram_read_en)       check_ev(EV_RD,   ram_address, 32'h0,         words_remaining);
            if (fifo_push)         check_ev(EV_PUSH, ram_address, fifo_data_out, words_remaining);
            if (ram_write_en)      check_ev(EV_WR,   ram_address, ram_data_out,  words_remaining);
            if (transfer_complete) check_ev(EV_DONE, ram_address, 32'h0,         words_remaining);
        end
    end

    task automatic start_xfer(input logic dir, input logic [15:0] len, input logic [63:0] addr);
        @(posedge clk); #1;
        start = 1'b1; direction = dir; length = len; address_init = addr;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_complete(input int exp_cycles, input string name);
        int n = 0;
        bit seen = 0;
        while (n < 300 && !seen) begin
            @(negedge clk);
            n++;
            n_checks++;
            if (!busy) begin
                n_fail++;
                $display("FAIL %s_busy: got busy=0 at cycle %0d, required 1", name, n);
            end
            if (transfer_complete) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: got no completion in %0d cycles, required completion", name, n);
        end else if (exp_cycles > 0 && n != exp_cycles) begin
            n_fail++;
            $display("FAIL %s_latency: got completion at cycle %0d, required %0d", name, n, exp_cycles);
        end
        @(negedge clk);
        n_checks++;
        if (busy || transfer_complete) begin
            n_fail++;
            $display("FAIL %s_idle: got busy=%0b complete=%0b, required 0 0", name, busy, transfer_complete);
        end
    endtask

    task automatic expect_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: got %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if (busy || transfer_complete || ram_read_en || ram_write_en || fifo_push || fifo_pop ||
            ram_address != 64'h0 || words_remaining != 16'h0) begin
            n_fail++;
            $display("FAIL %s: got busy=%0b cpl=%0b rd=%0b wr=%0b push=%0b pop=%0b addr=%0h rem=%0d, required all 0",
                     name, busy, transfer_complete, ram_read_en, ram_write_en, fifo_push, fifo_pop,
                     ram_address, words_remaining);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: RAM->FIFO, len 6 from address 0
        for (int i = 0; i < 6; i++) begin
            expect_ev(EV_RD,   64'(4 * i), 32'h0,       16'(6 - i));
            expect_ev(EV_PUSH, 64'(4 * i), 32'(4 * i),  16'(6 - i));
        end
        expect_ev(EV_DONE, 64'd24, 32'h0, 16'd0);
        start_xfer(1'b1, 16'd6, 64'd0);
        wait_complete(13, "ram_to_fifo");
        expect_drained("ram_to_fifo");

        // 2: FIFO->RAM, len 5 at address 12, FIFO preloaded
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            fq.push_back(32'hA000_0000 + 32'(i));
            expect_ev(EV_WR, 64'(12 + 4 * i), 32'hA000_0000 + 32'(i), 16'(5 - i));
        end
        expect_ev(EV_DONE, 64'd32, 32'h0, 16'd0);
        start_xfer(1'b0, 16'd5, 64'd12);
        wait_complete(6, "fifo_to_ram");
        expect_drained("fifo_to_ram");

        // 3a: FIFO full for the first 4 RD cycles
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_ev(EV_RD,   64'(4 * i), 32'h0,      16'(3 - i));
            expect_ev(EV_PUSH, 64'(4 * i), 32'(4 * i), 16'(3 - i));
        end
        expect_ev(EV_DONE, 64'd12, 32'h0, 16'd0);
        start_xfer(1'b1, 16'd3, 64'd0);
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (ram_read_en || ram_address != 64'h0 || !busy) begin
                n_fail++;
                $display("FAIL stall_full: got rd=%0b addr=%0h busy=%0b, required rd=0 addr=0 busy=1",
                         ram_read_en, ram_address, busy);
            end
        end
        @(posedge clk); #1;
        fifo_full = 1'b0;
        wait_complete(7, "stall_full");
        expect_drained("stall_full");

        // 3b: FIFO->RAM with empty gaps
        for (int i = 0; i < 3; i++)
            expect_ev(EV_WR, 64'(128 + 4 * i), 32'hB000_0000 + 32'(i), 16'(3 - i));
        expect_ev(EV_DONE, 64'd140, 32'h0, 16'd0);
        start_xfer(1'b0, 16'd3, 64'd128);
        repeat (2) @(posedge clk);
        #1 fq.push_back(32'hB000_0000);
        repeat (3) @(posedge clk);
        #1 fq.push_back(32'hB000_0001);
        #0 fq.push_back(32'hB000_0002);
        wait_complete(0, "empty_gaps");
        expect_drained("empty_gaps");

        // 4: zero length
        expect_ev(EV_DONE, 64'd100, 32'h0, 16'd0);
        start_xfer(1'b1, 16'd0, 64'd100);
        wait_complete(1, "zero_len");
        expect_drained("zero_len");

        // 5: start while busy is ignored
        for (int i = 0; i < 6; i++) begin
            expect_ev(EV_RD,   64'(4096 + 4 * i), 32'h0,             16'(6 - i));
            expect_ev(EV_PUSH, 64'(4096 + 4 * i), 32'(4096 + 4 * i), 16'(6 - i));
        end
        expect_ev(EV_DONE, 64'd4120, 32'h0, 16'd0);
        start_xfer(1'b1, 16'd6, 64'h1000);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; direction = 1'b0; length = 16'd2; address_init = 64'h40;
        @(posedge clk); #1;
        start = 1'b0;
        wait_complete(0, "start_busy");
        expect_drained("start_busy");

        // 6: reset after three words, then a fresh transfer
        for (int i = 0; i < 3; i++) begin
            expect_ev(EV_RD,   64'(512 + 4 * i), 32'h0,            16'(6 - i));
            expect_ev(EV_PUSH, 64'(512 + 4 * i), 32'(512 + 4 * i), 16'(6 - i));
        end
        start_xfer(1'b1, 16'd6, 64'h200);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_idle_outputs("reset_mid_transfer");
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("reset_held");
        rst = 1'b0;
        expect_drained("reset_mid_transfer");
        for (int i = 0; i < 2; i++) begin
            expect_ev(EV_RD,   64'(768 + 4 * i), 32'h0,            16'(2 - i));
            expect_ev(EV_PUSH, 64'(768 + 4 * i), 32'(768 + 4 * i), 16'(2 - i));
        end
        expect_ev(EV_DONE, 64'd776, 32'h0, 16'd0);
        start_xfer(1'b1, 16'd2, 64'h300);
        wait_complete(5, "after_reset");
        expect_drained("after_reset");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
